// File: rtl/execute_muldiv_unit.sv
// rtl/execute_muldiv_unit.sv - iterative RV64M multiply/divide unit with valid/ready handshake
// Define MULDIV_EARLY_OUT_EN to retire trivial ops (div by zero, overflow, small quotient, zero multiply) early.
module execute_muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;

  logic [2:0]        opReg;
  logic              wordReg, negAReg, negBReg, divZeroReg, ovfReg, skip;
  logic [XLEN-1:0]   aExtReg, dvsr, mplier, quo, rem;
  logic [2*XLEN-1:0] acc, mcand;
  logic [TAG_W-1:0]  tagReg;
  logic [CW-1:0]     cnt, nIter;

  // Request conditioning: extend per op/word, then split into sign and magnitude.
  logic            sgn1, sgn2, isDivIn, negA, negB, divZero, ovf, earlyHit;
  logic [XLEN-1:0] aExt, bExt, magA, magB, minVal;
  always_comb begin
    sgn1    = !(in_op == 3'd3 || in_op == 3'd5 || in_op == 3'd7);
    sgn2    = (in_op == 3'd0 || in_op == 3'd1 || in_op == 3'd4 || in_op == 3'd6);
    isDivIn = in_op[2];
    aExt    = in_word ? {{(XLEN-32){sgn1 & in_src1[31]}}, in_src1[31:0]} : in_src1;
    bExt    = in_word ? {{(XLEN-32){sgn2 & in_src2[31]}}, in_src2[31:0]} : in_src2;
    negA    = sgn1 & aExt[XLEN-1];
    negB    = sgn2 & bExt[XLEN-1];
    magA    = negA ? -aExt : aExt;
    magB    = negB ? -bExt : bExt;
    minVal  = in_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    divZero = isDivIn && (magB == '0);
    ovf     = isDivIn && sgn1 && (aExt == minVal) && (bExt == '1);
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign earlyHit = isDivIn ? (divZero || ovf || (magB > magA)) : ((magA == '0) || (magB == '0));
`else
  assign earlyHit = 1'b0;
`endif

  // Restoring divide step: borrow out of the subtract means the divisor did not fit.
  logic [XLEN:0] remTmp, remSub;
  assign remTmp = {rem, quo[XLEN-1]};
  assign remSub = remTmp - {1'b0, dvsr};
  assign nIter  = wordReg ? CW'(32) : CW'(XLEN);

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q, r, res;
  always_comb begin
    prod = (negAReg ^ negBReg) ? -acc : acc;
    q    = (negAReg ^ negBReg) ? -quo : quo;
    r    = negAReg ? -rem : rem;
    if (divZeroReg) begin
      q = '1;
      r = aExtReg;
    end else if (ovfReg) begin
      q = aExtReg;
      r = '0;
    end
    case (opReg)
      3'd0:             res = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       res = q;
      default:          res = r;
    endcase
    if (wordReg) res = {{(XLEN-32){res[31]}}, res[31:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_result <= '0;
      out_tag    <= '0;
      cnt        <= '0;
      skip       <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opReg      <= in_op;
          wordReg    <= in_word;
          negAReg    <= negA;
          negBReg    <= negB;
          divZeroReg <= divZero;
          ovfReg     <= ovf;
          aExtReg    <= aExt;
          tagReg     <= in_tag;
          skip       <= earlyHit;
          acc        <= '0;
          mcand      <= {{XLEN{1'b0}}, magA};
          mplier     <= magB;
          dvsr       <= magB;
          rem        <= earlyHit ? magA : '0;
          quo        <= earlyHit ? '0 : (in_word ? (magA << (XLEN-32)) : magA);
          cnt        <= '0;
          state      <= CALC;
        end
        CALC: if (cnt == nIter) begin
          out_result <= res;
          out_tag    <= tagReg;
          state      <= DONE;
        end else if (skip) begin
          cnt <= nIter;
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= remSub[XLEN] ? remTmp[XLEN-1:0] : remSub[XLEN-1:0];
          quo    <= {quo[XLEN-2:0], ~remSub[XLEN]};
          cnt    <= cnt + 1'b1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
endmodule
